// File: rtl/vit322_pkg.sv
// Shared types and constants for the (3,2,2) Viterbi node-sync controller.
package vit322_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MONITOR,
    ST_SLIP,
    ST_FLUSH
  } state_t;

  localparam int NUM_PHASES     = 3;
  localparam int DEF_WIN_LEN    = 32;
  localparam int DEF_ERR_THRESH = 4;
  localparam int DEF_FLUSH_CYC  = 8;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_LOCK_WINS  = 4;
  localparam int SLIP_W         = 8;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == 2'(NUM_PHASES - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/vit_win_judge_322.sv
// Window symbol/error counters with end-of-window and fail strobes.
module vit_win_judge_322
  import vit322_pkg::*;
#(
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic we,
  input  logic error,
  output logic win_end,
  output logic win_fail
);

  localparam int WW = $clog2(WIN_LEN);
  localparam int EW = $clog2(ERR_THRESH + 1);

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic          sym_err;
  logic [EW:0]   err_sum;

  assign sym_err  = active & we & error;
  assign err_sum  = {1'b0, err_cnt} + (EW+1)'(sym_err);
  assign win_end  = active & we & (win_cnt == WW'(WIN_LEN - 1));
  assign win_fail = win_end & (err_sum >= (EW+1)'(ERR_THRESH));

  always_ff @(posedge clock) begin
    if (reset || !active || win_end) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (we) begin
      win_cnt <= win_cnt + 1'b1;
      // saturate so a burst of errors can never wrap to a pass
      if (sym_err && (err_cnt < EW'(ERR_THRESH)))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vit_resync_ctrl_322.sv
// Node-sync FSM: settle, judge windows, slip phase, flush decoder.
// Build option: define VIT_RESYNC_POL_EN to add the polarity hypothesis.
module vit_resync_ctrl_322
  import vit322_pkg::*;
#(
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int ERR_THRESH = DEF_ERR_THRESH,
  parameter int FLUSH_CYC  = DEF_FLUSH_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_WINS  = DEF_LOCK_WINS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              we,
  input  logic              error,
  output logic [1:0]        phase,
  output logic              invert,
  output logic              flush,
  output logic              locked,
  output logic [SLIP_W-1:0] slip_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int CW = $clog2(LOCK_WINS + 1);

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [FW-1:0] flush_cnt;
  logic [CW-1:0] clean_cnt;
  logic          win_end;
  logic          win_fail;

  vit_win_judge_322 #(
    .WIN_LEN    (WIN_LEN),
    .ERR_THRESH (ERR_THRESH)
  ) u_judge (
    .clock    (clock),
    .reset    (reset),
    .active   (state == ST_MONITOR),
    .we       (we),
    .error    (error),
    .win_end  (win_end),
    .win_fail (win_fail)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      flush      <= 1'b0;
      locked     <= 1'b0;
      slip_cnt   <= '0;
      settle_cnt <= '0;
      flush_cnt  <= '0;
      clean_cnt  <= '0;
    end else if (!enable) begin
      // phase and slip history survive a disable
      state      <= ST_IDLE;
      flush      <= 1'b0;
      locked     <= 1'b0;
      settle_cnt <= '0;
      flush_cnt  <= '0;
      clean_cnt  <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          settle_cnt <= '0;
          flush_cnt  <= '0;
          clean_cnt  <= '0;
          state      <= ST_SETTLE;
        end
        (state == ST_SETTLE): begin
          if (we) begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
              settle_cnt <= '0;
              state      <= ST_MONITOR;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        (state == ST_MONITOR): begin
          if (win_fail) begin
            clean_cnt <= '0;
            locked    <= 1'b0;
            state     <= ST_SLIP;
          end else if (win_end) begin
            if (clean_cnt < CW'(LOCK_WINS))
              clean_cnt <= clean_cnt + 1'b1;
            if (clean_cnt >= CW'(LOCK_WINS - 1))
              locked <= 1'b1;
          end
        end
        (state == ST_SLIP): begin
          phase <= next_phase(phase);
          if (slip_cnt != '1)
            slip_cnt <= slip_cnt + 1'b1;
          flush     <= 1'b1;
          flush_cnt <= '0;
          state     <= ST_FLUSH;
        end
        (state == ST_FLUSH): begin
          if (flush_cnt == FW'(FLUSH_CYC - 1)) begin
            flush     <= 1'b0;
            flush_cnt <= '0;
            state     <= ST_SETTLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef VIT_RESYNC_POL_EN
  logic inv_q;

  always_ff @(posedge clock) begin
    if (reset)
      inv_q <= 1'b0;
    else if (enable && state == ST_SLIP && phase == 2'(NUM_PHASES - 1))
      inv_q <= ~inv_q;
  end

  assign invert = inv_q;
`else
  assign invert = 1'b0;
`endif

endmodule
